dispatch_ctrl: RTL and testbench

DISPATCH_CTRL -- requirements
Module: dispatch_ctrl

---
 rtl/dispatch_ctrl.sv | 98 +++++++++
 tb/tb_dispatch_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/dispatch_ctrl.sv
// Dispatch hazard controller: tracks ROB/RS/free-list credits, gates dispatch and
// fetch, and holds a fixed-length FLUSH window after a branch mispredict.
module dispatch_ctrl #(
    parameter int ROB_SIZE     = 32,
    parameter int RS_SIZE      = 16,
    parameter int FL_SIZE      = 32,
    parameter int FLUSH_CYCLES = 2,
    localparam int MAXSZ = (ROB_SIZE > RS_SIZE)
                           ? ((ROB_SIZE > FL_SIZE) ? ROB_SIZE : FL_SIZE)
                           : ((RS_SIZE > FL_SIZE) ? RS_SIZE : FL_SIZE),
    localparam int CW    = $clog2(MAXSZ) + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          iq_valid,
    input  logic          iq_needs_dest,
    input  logic          iq_full,
    input  logic          rob_retire,
    input  logic          rs_issue,
    input  logic          fl_return,
    input  logic          branch_incorrect,
    input  logic [CW-1:0] rob_free_in,
    input  logic [CW-1:0] rs_free_in,
    input  logic [CW-1:0] fl_free_in,
    output logic          dispatch_no_hazard,
    output logic          fetch_stall,
    output logic [CW-1:0] rob_credit,
    output logic [CW-1:0] rs_credit,
    output logic [CW-1:0] fl_credit,
    output logic          in_flush,
    output logic [15:0]   stall_cycles
);
    localparam int FCW = ($clog2(FLUSH_CYCLES + 1) < 2) ? 2 : $clog2(FLUSH_CYCLES + 1);
    localparam logic [CW-1:0] ROB_MAX = CW'(ROB_SIZE);
    localparam logic [CW-1:0] RS_MAX  = CW'(RS_SIZE);
    localparam logic [CW-1:0] FL_MAX  = CW'(FL_SIZE);

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    state_t         r_state;
    logic [FCW-1:0] r_flush_cnt;
    logic [CW-1:0]  r_rob, r_rs, r_fl;
    logic [15:0]    r_stall;
    logic           w_fire;

    // Simultaneous take and give cancel; a give at full capacity is dropped.
    function automatic logic [CW-1:0] upd(input logic [CW-1:0] cur, input logic dec,
                                          input logic inc, input logic [CW-1:0] size);
        if (dec && !inc)                    return cur - 1'b1;
        else if (inc && !dec && cur < size) return cur + 1'b1;
        else                                return cur;
    endfunction

    function automatic logic [CW-1:0] clamp(input logic [CW-1:0] v, input logic [CW-1:0] size);
        return (v > size) ? size : v;
    endfunction

    assign dispatch_no_hazard = (r_state == RUN) && (r_rob != '0) && (r_rs != '0) &&
                                ((r_fl != '0) || !iq_needs_dest);
    assign fetch_stall  = iq_full || (r_state == FLUSH);
    assign w_fire       = iq_valid && dispatch_no_hazard;
    assign rob_credit   = r_rob;
    assign rs_credit    = r_rs;
    assign fl_credit    = r_fl;
    assign in_flush     = (r_state == FLUSH);
    assign stall_cycles = r_stall;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= RUN;
            r_flush_cnt <= '0;
            r_rob       <= ROB_MAX;
            r_rs        <= RS_MAX;
            r_fl        <= FL_MAX;
            r_stall     <= '0;
        end else begin
            if (r_state == RUN && iq_valid && !dispatch_no_hazard && r_stall != 16'hFFFF)
                r_stall <= r_stall + 16'd1;

            if (branch_incorrect) begin
                r_state     <= FLUSH;
                r_flush_cnt <= FCW'(FLUSH_CYCLES - 1);
                r_rob       <= clamp(rob_free_in, ROB_MAX);
                r_rs        <= clamp(rs_free_in, RS_MAX);
                r_fl        <= clamp(fl_free_in, FL_MAX);
            end else begin
                // w_fire is already zero in FLUSH, so only returns move credits there.
                r_rob <= upd(r_rob, w_fire, rob_retire, ROB_MAX);
                r_rs  <= upd(r_rs, w_fire, rs_issue, RS_MAX);
                r_fl  <= upd(r_fl, w_fire && iq_needs_dest, fl_return, FL_MAX);
                if (r_state == FLUSH) begin
                    if (r_flush_cnt == '0) r_state     <= RUN;
                    else                   r_flush_cnt <= r_flush_cnt - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed self-checking bench for dispatch_ctrl with default parameters.
module tb_dispatch_ctrl;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iq_valid = 0, iq_needs_dest = 0, iq_full = 0;
    logic       rob_retire = 0, rs_issue = 0, fl_return = 0, branch_incorrect = 0;
    logic [5:0] rob_free_in = 0, rs_free_in = 0, fl_free_in = 0;
    logic       dispatch_no_hazard, fetch_stall, in_flush;
    logic [5:0] rob_credit, rs_credit, fl_credit;
    logic [15:0] stall_cycles;
    int checks = 0;
    int errors = 0;

    dispatch_ctrl dut (
        .clock(clock), .reset(reset), .iq_valid(iq_valid), .iq_needs_dest(iq_needs_dest),
        .iq_full(iq_full), .rob_retire(rob_retire), .rs_issue(rs_issue), .fl_return(fl_return),
        .branch_incorrect(branch_incorrect), .rob_free_in(rob_free_in), .rs_free_in(rs_free_in),
        .fl_free_in(fl_free_in), .dispatch_no_hazard(dispatch_no_hazard),
        .fetch_stall(fetch_stall), .rob_credit(rob_credit), .rs_credit(rs_credit),
        .fl_credit(fl_credit), .in_flush(in_flush), .stall_cycles(stall_cycles)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1; step(); step(); reset = 0;
        iq_full = 1; #1;
        checks++; if (rob_credit !== 6'd32) begin errors++; $display("FAIL rst_rob got %0d exp 32", rob_credit); end
        checks++; if (rs_credit !== 6'd16) begin errors++; $display("FAIL rst_rs got %0d exp 16", rs_credit); end
        checks++; if (fl_credit !== 6'd32) begin errors++; $display("FAIL rst_fl got %0d exp 32", fl_credit); end
        checks++; if (in_flush !== 1'b0) begin errors++; $display("FAIL rst_in_flush got %b exp 0", in_flush); end
        checks++; if (dispatch_no_hazard !== 1'b1) begin errors++; $display("FAIL rst_dnh got %b exp 1", dispatch_no_hazard); end
        checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL rst_stall got %0d exp 0", stall_cycles); end
        checks++; if (fetch_stall !== 1'b1) begin errors++; $display("FAIL rst_fetch_stall_full got %b exp 1", fetch_stall); end
        iq_full = 0; #1;
        checks++; if (fetch_stall !== 1'b0) begin errors++; $display("FAIL rst_fetch_stall got %b exp 0", fetch_stall); end
    endtask

    task automatic test_fill();
        iq_valid = 1; iq_needs_dest = 1;
        repeat (16) step();
        checks++; if (rs_credit !== 6'd0) begin errors++; $display("FAIL fill_rs got %0d exp 0", rs_credit); end
        checks++; if (rob_credit !== 6'd16) begin errors++; $display("FAIL fill_rob got %0d exp 16", rob_credit); end
        checks++; if (fl_credit !== 6'd16) begin errors++; $display("FAIL fill_fl got %0d exp 16", fl_credit); end
        checks++; if (dispatch_no_hazard !== 1'b0) begin errors++; $display("FAIL fill_dnh got %b exp 0", dispatch_no_hazard); end
        checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL fill_stall0 got %0d exp 0", stall_cycles); end
        repeat (3) step();
        checks++; if (stall_cycles !== 16'd3) begin errors++; $display("FAIL fill_stall3 got %0d exp 3", stall_cycles); end
        iq_valid = 0;
    endtask

    task automatic test_rs_return();
        // Load rob=20, rs=0, fl=5 through a recovery, then wait it out.
        branch_incorrect = 1; rob_free_in = 20; rs_free_in = 0; fl_free_in = 5;
        step(); branch_incorrect = 0;
        step(); step();
        checks++; if (in_flush !== 1'b0) begin errors++; $display("FAIL rsret_in_flush got %b exp 0", in_flush); end
        checks++; if (dispatch_no_hazard !== 1'b0) begin errors++; $display("FAIL rsret_dnh0 got %b exp 0", dispatch_no_hazard); end
        iq_needs_dest = 0; rs_issue = 1; step(); rs_issue = 0;
        checks++; if (dispatch_no_hazard !== 1'b1) begin errors++; $display("FAIL rsret_dnh1 got %b exp 1", dispatch_no_hazard); end
        iq_valid = 1; step(); iq_valid = 0;
        checks++; if (rs_credit !== 6'd0) begin errors++; $display("FAIL rsret_rs got %0d exp 0", rs_credit); end
        checks++; if (fl_credit !== 6'd5) begin errors++; $display("FAIL rsret_fl got %0d exp 5", fl_credit); end
        checks++; if (rob_credit !== 6'd19) begin errors++; $display("FAIL rsret_rob got %0d exp 19", rob_credit); end
        checks++; if (stall_cycles !== 16'd3) begin errors++; $display("FAIL rsret_stall got %0d exp 3", stall_cycles); end
    endtask

    task automatic test_same_cycle();
        rs_issue = 1; step(); rs_issue = 0;  // rs 0 -> 1
        iq_valid = 1; iq_needs_dest = 1; rob_retire = 1; rs_issue = 1; fl_return = 1;
        step();
        iq_valid = 0; rob_retire = 0; rs_issue = 0; fl_return = 0;
        checks++; if (rob_credit !== 6'd19) begin errors++; $display("FAIL same_rob got %0d exp 19", rob_credit); end
        checks++; if (rs_credit !== 6'd1) begin errors++; $display("FAIL same_rs got %0d exp 1", rs_credit); end
        checks++; if (fl_credit !== 6'd5) begin errors++; $display("FAIL same_fl got %0d exp 5", fl_credit); end
        fl_return = 1; step(); fl_return = 0;
        checks++; if (fl_credit !== 6'd6) begin errors++; $display("FAIL ret_fl got %0d exp 6", fl_credit); end
    endtask

    task automatic test_flush();
        branch_incorrect = 1; rob_free_in = 20; rs_free_in = 40; fl_free_in = 7;
        step(); branch_incorrect = 0;
        iq_valid = 1; iq_needs_dest = 1; #1;
        checks++; if (rob_credit !== 6'd20 || rs_credit !== 6'd16 || fl_credit !== 6'd7) begin errors++; $display("FAIL flush_load got %0d/%0d/%0d exp 20/16/7", rob_credit, rs_credit, fl_credit); end
        checks++; if (in_flush !== 1'b1 || fetch_stall !== 1'b1) begin errors++; $display("FAIL flush_c1 got in_flush=%b fetch_stall=%b exp 1/1", in_flush, fetch_stall); end
        checks++; if (dispatch_no_hazard !== 1'b0) begin errors++; $display("FAIL flush_dnh got %b exp 0", dispatch_no_hazard); end
        rob_retire = 1; rs_issue = 1;
        step(); rob_retire = 0; rs_issue = 0;
        checks++; if (in_flush !== 1'b1 || fetch_stall !== 1'b1) begin errors++; $display("FAIL flush_c2 got in_flush=%b fetch_stall=%b exp 1/1", in_flush, fetch_stall); end
        checks++; if (rob_credit !== 6'd21 || rs_credit !== 6'd16 || fl_credit !== 6'd7) begin errors++; $display("FAIL flush_ret got %0d/%0d/%0d exp 21/16/7", rob_credit, rs_credit, fl_credit); end
        iq_valid = 0;
        step();
        checks++; if (in_flush !== 1'b0 || fetch_stall !== 1'b0) begin errors++; $display("FAIL flush_exit got in_flush=%b fetch_stall=%b exp 0/0", in_flush, fetch_stall); end
        checks++; if (dispatch_no_hazard !== 1'b1) begin errors++; $display("FAIL flush_exit_dnh got %b exp 1", dispatch_no_hazard); end
        checks++; if (stall_cycles !== 16'd3) begin errors++; $display("FAIL flush_stall got %0d exp 3", stall_cycles); end
    endtask

    task automatic test_reflush();
        branch_incorrect = 1; rob_free_in = 10; rs_free_in = 3; fl_free_in = 4;
        step(); branch_incorrect = 0;
        step();
        checks++; if (in_flush !== 1'b1) begin errors++; $display("FAIL reflush_c2 got %b exp 1", in_flush); end
        branch_incorrect = 1; rob_free_in = 12; rs_free_in = 5; fl_free_in = 6;
        step(); branch_incorrect = 0;
        checks++; if (in_flush !== 1'b1) begin errors++; $display("FAIL reflush_ext1 got %b exp 1", in_flush); end
        checks++; if (rob_credit !== 6'd12 || rs_credit !== 6'd5 || fl_credit !== 6'd6) begin errors++; $display("FAIL reflush_load got %0d/%0d/%0d exp 12/5/6", rob_credit, rs_credit, fl_credit); end
        step();
        checks++; if (in_flush !== 1'b1) begin errors++; $display("FAIL reflush_ext2 got %b exp 1", in_flush); end
        step();
        checks++; if (in_flush !== 1'b0) begin errors++; $display("FAIL reflush_exit got %b exp 0", in_flush); end
        branch_incorrect = 1; rob_free_in = 1; rs_free_in = 1; fl_free_in = 1;
        step();
        reset = 1;  // branch_incorrect still high: reset must win
        step(); reset = 0; branch_incorrect = 0;
        checks++; if (in_flush !== 1'b0) begin errors++; $display("FAIL rstflush_in_flush got %b exp 0", in_flush); end
        checks++; if (rob_credit !== 6'd32 || rs_credit !== 6'd16 || fl_credit !== 6'd32) begin errors++; $display("FAIL rstflush_cred got %0d/%0d/%0d exp 32/16/32", rob_credit, rs_credit, fl_credit); end
        checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL rstflush_stall got %0d exp 0", stall_cycles); end
    endtask

    task automatic test_saturate();
        rob_retire = 1; step(); rob_retire = 0;
        checks++; if (rob_credit !== 6'd32) begin errors++; $display("FAIL rob_cap got %0d exp 32", rob_credit); end
        // fl=0 with a dest-writing instruction keeps dispatch blocked.
        branch_incorrect = 1; rob_free_in = 20; rs_free_in = 10; fl_free_in = 0;
        step(); branch_incorrect = 0;
        step(); step();
        iq_valid = 1; iq_needs_dest = 1;
        repeat (100) step();
        checks++; if (stall_cycles !== 16'd100) begin errors++; $display("FAIL stall100 got %0d exp 100", stall_cycles); end
        branch_incorrect = 1; step(); branch_incorrect = 0;  // RUN cycle counts
        step(); step();                                      // FLUSH cycles do not
        checks++; if (stall_cycles !== 16'd101) begin errors++; $display("FAIL stall_keep got %0d exp 101", stall_cycles); end
        repeat (69900) step();
        checks++; if (stall_cycles !== 16'hFFFF) begin errors++; $display("FAIL stall_sat got %0h exp ffff", stall_cycles); end
        iq_valid = 0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_rs_return();
        test_same_cycle();
        test_flush();
        test_reflush();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
